// File: rtl/local_ram_arbiter.sv
// rtl/local_ram_arbiter.sv - round-robin IF/LSU arbiter and access sequencer for the byte-lane local RAM
module local_ram_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_COUNT = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    output logic                  o_if_err,
    input  logic                  i_ls_req,
    input  logic                  i_ls_we,
    input  logic [2:0]            i_ls_funct3,
    input  logic [ADDR_WIDTH-1:0] i_ls_addr,
    input  logic [DATA_WIDTH-1:0] i_ls_wdata,
    output logic                  o_ls_gnt,
    output logic                  o_ls_rvalid,
    output logic [DATA_WIDTH-1:0] o_ls_rdata,
    output logic                  o_ls_err,
    output logic                  o_ram_clk_en,
    output logic [ADDR_WIDTH-1:0] o_ram_read_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_read_data,
    output logic                  o_ram_write_en,
    output logic [3:0]            o_ram_byte_en,
    output logic [ADDR_WIDTH-1:0] o_ram_write_addr,
    output logic [DATA_WIDTH-1:0] o_ram_write_data
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  last_ls_q, last_ls_d;
    logic                  sel_ls_q, sel_ls_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            boff_q, boff_d;
    logic [ADDR_WIDTH-1:0] widx_q, widx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            ben_q, ben_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  if_err_q, if_err_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  ls_rvalid_q, ls_rvalid_d;
    logic                  ls_err_q, ls_err_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;

    logic                  if_gnt, ls_gnt;
    logic [ADDR_WIDTH-1:0] req_addr, offset, req_widx;
    logic                  below_base, out_of_range;
    logic                  ls_illegal, ls_misaligned, grant_err;
    logic [3:0]            st_ben;
    logic [DATA_WIDTH-1:0] st_data;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;

    // Grants only exist in IDLE; ties go to whoever was not served last.
    assign if_gnt = i_rst_n && (state_q == S_IDLE) && i_if_req && (!i_ls_req || last_ls_q);
    assign ls_gnt = i_rst_n && (state_q == S_IDLE) && i_ls_req && (!i_if_req || !last_ls_q);

    assign req_addr              = ls_gnt ? i_ls_addr : i_if_addr;
    assign {below_base, offset}  = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign req_widx              = offset >> 2;
    assign out_of_range          = below_base || (req_widx >= ADDR_WIDTH'(ADDR_COUNT));

    always_comb begin
        ls_illegal    = 1'b0;
        ls_misaligned = 1'b0;
        st_ben        = 4'b1111;
        st_data       = i_ls_wdata;
        case (i_ls_funct3)
            3'b000: begin
                st_ben  = 4'b0001 << i_ls_addr[1:0];
                st_data = {4{i_ls_wdata[7:0]}};
            end
            3'b001: begin
                ls_misaligned = i_ls_addr[0];
                st_ben        = 4'b0011 << {i_ls_addr[1], 1'b0};
                st_data       = {2{i_ls_wdata[15:0]}};
            end
            3'b010: ls_misaligned = (i_ls_addr[1:0] != 2'b00);
            3'b100: ls_illegal    = i_ls_we;
            3'b101: begin
                ls_illegal    = i_ls_we;
                ls_misaligned = i_ls_addr[0];
            end
            default: ls_illegal = 1'b1;
        endcase
        grant_err = ls_gnt ? (out_of_range || ls_illegal || ls_misaligned)
                           : (out_of_range || (i_if_addr[1:0] != 2'b00));
    end

    always_comb begin
        ld_data = i_ram_read_data;
        case (boff_q)
            2'd0:    ld_byte = i_ram_read_data[7:0];
            2'd1:    ld_byte = i_ram_read_data[15:8];
            2'd2:    ld_byte = i_ram_read_data[23:16];
            default: ld_byte = i_ram_read_data[31:24];
        endcase
        ld_half = boff_q[1] ? i_ram_read_data[31:16] : i_ram_read_data[15:0];
        if (sel_ls_q) begin
            case (funct3_q)
                3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
                3'b100:  ld_data = {24'd0, ld_byte};
                3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
                3'b101:  ld_data = {16'd0, ld_half};
                default: ld_data = i_ram_read_data;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        last_ls_d   = last_ls_q;
        sel_ls_d    = sel_ls_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        boff_d      = boff_q;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        ben_d       = ben_q;
        if_rvalid_d = 1'b0;
        if_err_d    = if_err_q;
        if_rdata_d  = if_rdata_q;
        ls_rvalid_d = 1'b0;
        ls_err_d    = ls_err_q;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (if_gnt || ls_gnt) begin
                    last_ls_d = ls_gnt;
                    if (grant_err) begin
                        // Rejected requests answer next cycle without touching the RAM.
                        if (ls_gnt) begin
                            ls_rvalid_d = 1'b1;
                            ls_err_d    = 1'b1;
                            ls_rdata_d  = '0;
                        end else begin
                            if_rvalid_d = 1'b1;
                            if_err_d    = 1'b1;
                            if_rdata_d  = '0;
                        end
                    end else begin
                        state_d  = S_ACCESS;
                        sel_ls_d = ls_gnt;
                        we_d     = ls_gnt && i_ls_we;
                        funct3_d = ls_gnt ? i_ls_funct3 : 3'b010;
                        boff_d   = req_addr[1:0];
                        widx_d   = req_widx;
                        wdata_d  = st_data;
                        ben_d    = st_ben;
                    end
                end
            end
            S_ACCESS: begin
                if (sel_ls_q && we_q) begin
                    state_d     = S_IDLE;
                    ls_rvalid_d = 1'b1;
                    ls_err_d    = 1'b0;
                    ls_rdata_d  = '0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_IDLE;
                if (sel_ls_q) begin
                    ls_rvalid_d = 1'b1;
                    ls_err_d    = 1'b0;
                    ls_rdata_d  = ld_data;
                end else begin
                    if_rvalid_d = 1'b1;
                    if_err_d    = 1'b0;
                    if_rdata_d  = ld_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            last_ls_q   <= 1'b0;
            sel_ls_q    <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            boff_q      <= 2'd0;
            widx_q      <= '0;
            wdata_q     <= '0;
            ben_q       <= 4'd0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_ls_q   <= last_ls_d;
            sel_ls_q    <= sel_ls_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            boff_q      <= boff_d;
            widx_q      <= widx_d;
            wdata_q     <= wdata_d;
            ben_q       <= ben_d;
            if_rvalid_q <= if_rvalid_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_err_q    <= ls_err_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign o_if_gnt         = if_gnt;
    assign o_ls_gnt         = ls_gnt;
    assign o_if_rvalid      = if_rvalid_q;
    assign o_if_err         = if_err_q;
    assign o_if_rdata       = if_rdata_q;
    assign o_ls_rvalid      = ls_rvalid_q;
    assign o_ls_err         = ls_err_q;
    assign o_ls_rdata       = ls_rdata_q;
    assign o_ram_clk_en     = (state_q == S_ACCESS);
    assign o_ram_write_en   = (state_q == S_ACCESS) && sel_ls_q && we_q;
    assign o_ram_byte_en    = o_ram_write_en ? ben_q : 4'd0;
    assign o_ram_read_addr  = widx_q;
    assign o_ram_write_addr = widx_q;
    assign o_ram_write_data = wdata_q;

endmodule
